int_ctrl: RTL and testbench

//  Memory-mapped interrupt controller that owns the CPU INT input.
//  - Synchronises N_SRC peripheral requests, latches them as pending and masks them.
//  - Picks one winner by fixed priority and sequences a request/ack/end-of-interrupt handshake with the CPU.
//  - Sits on the CPU data bus (mem_w/Addr_out/Data_out) beside data memory; its read data joins the Data_in mux.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_sync.sv | 27 ++
 rtl/int_ctrl.sv | 132 +++++++++++++
 tb/tb_int_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - register offsets, FSM state encoding and widths for int_ctrl
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [4:0] OFF_PEND = 5'h00;
    localparam logic [4:0] OFF_MASK = 5'h04;
    localparam logic [4:0] OFF_MODE = 5'h08;
    localparam logic [4:0] OFF_CUR  = 5'h0C;
    localparam logic [4:0] OFF_ACK  = 5'h10;
    localparam logic [4:0] OFF_EOI  = 5'h14;

    localparam int ID_W    = 4;
    localparam int MAX_SRC = 16;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - two-flop synchroniser plus a third flop for rising-edge detect
module int_sync (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= src_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - memory-mapped interrupt controller: pending/mask/mode registers,
// fixed-priority winner and request/ack/EOI handshake towards the CPU INT input
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mem_w,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      wdata,
    output logic             sel,
    output logic [31:0]      rdata,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id
);

    logic [N_SRC-1:0]   s2, rise;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   mask_q, mode_q;
    logic [N_SRC-1:0]   w1c, ack_clr_vec;
    logic [MAX_SRC-1:0] act;
    logic [ID_W-1:0]    id_q, id_d, win_id;
    logic               win_vld, ack_clr;
    state_e             state_q, state_d;
    logic [4:0]         off;
    logic               wr, ack_wr, eoi_wr;
    logic               unused_wdata;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        int_sync u_sync (
            .clk     (clk),
            .reset   (reset),
            .src_i   (irq_src[g]),
            .level_o (s2[g]),
            .rise_o  (rise[g])
        );
    end

    assign sel    = (addr_in[31:5] == BASE_ADDR[31:5]);
    assign off    = addr_in[4:0];
    assign wr     = mem_w & sel;
    assign ack_wr = wr & (off == OFF_ACK);
    assign eoi_wr = wr & (off == OFF_EOI);
    assign w1c    = (wr && off == OFF_PEND) ? wdata[N_SRC-1:0] : '0;
    assign act    = MAX_SRC'(pend_q & mask_q);

    assign unused_wdata = ^wdata[31:N_SRC];

    // Descending scan so the lowest active index is the last assignment and wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_ASSERT;
                    id_d    = win_id;
                end
            end
            ST_ASSERT: begin
                if (ack_wr) begin
                    state_d = ST_SERVICE;
                    ack_clr = 1'b1;
                end else if (!act[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr_vec[i] = ack_clr && (id_q == ID_W'(i));
        end
    end

    // Edge sources hold until cleared, with a new edge beating any clear; level sources follow s2.
    assign pend_d = (mode_q & ((pend_q & ~w1c & ~ack_clr_vec) | rise)) | (~mode_q & s2);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
            if (wr && off == OFF_MASK) mask_q <= wdata[N_SRC-1:0];
            if (wr && off == OFF_MODE) mode_q <= wdata[N_SRC-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_PEND: rdata = 32'(pend_q);
                OFF_MASK: rdata = 32'(mask_q);
                OFF_MODE: rdata = 32'(mode_q);
                OFF_CUR:  rdata = {22'd0, state_q, 4'd0, id_q};
                default:  rdata = '0;
            endcase
        end
    end

    assign int_req = (state_q == ST_ASSERT);
    assign int_id  = id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed and randomized bench for int_ctrl against a cycle-level behavioural model
module tb_int_ctrl;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_src = '0;
    logic          mem_w = 1'b0;
    logic [31:0]   addr_in = 32'h0000_1000;
    logic [31:0]   wdata = '0;
    logic          sel;
    logic [31:0]   rdata;
    logic          int_req;
    logic [3:0]    int_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ctrl #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .mem_w   (mem_w),
        .addr_in (addr_in),
        .wdata   (wdata),
        .sel     (sel),
        .rdata   (rdata),
        .int_req (int_req),
        .int_id  (int_id)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Model: state 0=idle, 1=asserting, 2=in service; smp[0] is the newest irq sample.
    bit [N-1:0] m_pend, m_mask, m_mode;
    int         m_state, m_id;
    bit [N-1:0] smp [3];
    bit         m_live = 1'b0;

    function automatic bit in_win(logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32);
    endfunction

    function automatic logic [31:0] exp_rdata(logic [31:0] a);
        if (!in_win(a)) return 32'd0;
        case (int'(a - BASE))
            0:       return 32'(m_pend);
            4:       return 32'(m_mask);
            8:       return 32'(m_mode);
            12:      return 32'((m_state << 8) | m_id);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step();
        bit [N-1:0] np, rise, lvl;
        int         ns, nid, woff;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_mode = '0;
            m_state = 0; m_id = 0;
            smp[0] = '0; smp[1] = '0; smp[2] = '0;
            m_live = 1'b1;
            return;
        end
        woff = (mem_w && in_win(addr_in)) ? int'(addr_in - BASE) : -1;
        lvl  = smp[1];
        rise = smp[1] & ~smp[2];
        ns   = m_state;
        nid  = m_id;
        case (m_state)
            0: for (int i = 0; i < N; i++) begin
                   if (m_pend[i] && m_mask[i]) begin ns = 1; nid = i; break; end
               end
            1: if (woff == 16) ns = 2;
               else if (!(m_pend[m_id] && m_mask[m_id])) ns = 0;
            2: if (woff == 20) ns = 0;
            default: ns = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (woff == 0 && wdata[i]) np[i] = 1'b0;
                if (m_state == 1 && woff == 16 && m_id == i) np[i] = 1'b0;
                if (rise[i]) np[i] = 1'b1;
            end else begin
                np[i] = lvl[i];
            end
        end
        if (woff == 4) m_mask = wdata[N-1:0];
        if (woff == 8) m_mode = wdata[N-1:0];
        smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = irq_src;
        m_pend = np; m_state = ns; m_id = nid;
    endfunction

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_live) begin
            check("int_req", 32'(int_req), 32'(m_state == 1));
            check("int_id",  32'(int_id),  32'(m_id));
            check("sel",     32'(sel),     32'(in_win(addr_in)));
            check("rdata",   rdata,        exp_rdata(addr_in));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
        mem_w = 1'b1; addr_in = BASE + 32'(off); wdata = d;
        @(negedge clk);
        mem_w = 1'b0; addr_in = 32'h0000_1000; wdata = '0;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
        addr_in = BASE + 32'(off);
        #1 d = rdata;
    endtask

    logic [31:0] rd;
    int          r;

    initial begin
        // Reset held for two edges
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("rst_req", 32'(int_req), 0);
        check("rst_id", 32'(int_id), 0);
        bus_read(5'h00, rd); check("rst_pend", rd, 0);
        bus_read(5'h04, rd); check("rst_mask", rd, 0);
        bus_read(5'h08, rd); check("rst_mode", rd, 0);
        cyc(1);

        // Single edge source, three-edge latency
        bus_write(5'h04, 32'h04);
        bus_write(5'h08, 32'h04);
        irq_src[2] = 1'b1;
        cyc(1);
        irq_src[2] = 1'b0;
        cyc(2);
        check("t2_req_early", 32'(int_req), 0);
        cyc(1);
        check("t2_req", 32'(int_req), 1);
        check("t2_id", 32'(int_id), 2);
        bus_write(5'h10, 32'h0);
        check("t2_req_ack", 32'(int_req), 0);
        bus_read(5'h00, rd); check("t2_pend_ack", rd, 0);
        bus_read(5'h0C, rd); check("t2_cur_service", rd, 32'h0000_0202);
        bus_write(5'h14, 32'h0);
        bus_read(5'h0C, rd); check("t2_cur_idle", 32'(rd[9:8]), 0);
        cyc(1);

        // Priority between two simultaneous edge sources
        bus_write(5'h04, 32'hFF);
        bus_write(5'h08, 32'hFF);
        bus_write(5'h00, 32'hFF);
        irq_src = 8'h22;
        cyc(4);
        check("t3_req", 32'(int_req), 1);
        check("t3_id", 32'(int_id), 1);
        irq_src = '0;
        bus_write(5'h10, 32'h0);
        bus_write(5'h14, 32'h0);
        check("t3_req_eoi", 32'(int_req), 0);
        cyc(1);
        check("t3_req_again", 32'(int_req), 1);
        check("t3_id_again", 32'(int_id), 5);
        bus_write(5'h10, 32'h0);
        bus_write(5'h14, 32'h0);
        bus_read(5'h00, rd); check("t3_pend_empty", rd, 0);
        cyc(1);

        // Level source withdrawn before ACK
        bus_write(5'h08, 32'h00);
        bus_write(5'h04, 32'h08);
        irq_src[3] = 1'b1;
        cyc(4);
        check("t4_req", 32'(int_req), 1);
        check("t4_id", 32'(int_id), 3);
        bus_write(5'h00, 32'h08);
        bus_read(5'h00, rd); check("t4_level_w1c", rd, 32'h08);
        irq_src[3] = 1'b0;
        cyc(3);
        check("t4_req_hold", 32'(int_req), 1);
        cyc(1);
        check("t4_req_drop", 32'(int_req), 0);
        bus_read(5'h0C, rd); check("t4_cur_idle", 32'(rd[9:8]), 0);
        cyc(1);

        // No nesting: request during service waits for EOI
        bus_write(5'h08, 32'h05);
        bus_write(5'h04, 32'h05);
        irq_src[2] = 1'b1;
        cyc(1);
        irq_src[2] = 1'b0;
        cyc(3);
        check("t5_req", 32'(int_req), 1);
        bus_write(5'h10, 32'h0);
        irq_src[0] = 1'b1;
        cyc(1);
        irq_src[0] = 1'b0;
        cyc(4);
        check("t5_req_service", 32'(int_req), 0);
        bus_read(5'h00, rd); check("t5_pend0", rd, 32'h01);
        bus_write(5'h14, 32'h0);
        check("t5_req_eoi", 32'(int_req), 0);
        cyc(1);
        check("t5_req_again", 32'(int_req), 1);
        check("t5_id", 32'(int_id), 0);
        bus_write(5'h10, 32'h0);
        bus_write(5'h14, 32'h0);

        // Reads are side-effect free, unmapped writes ignored, reset aborts service
        irq_src[2] = 1'b1;
        cyc(1);
        irq_src[2] = 1'b0;
        cyc(3);
        for (int i = 0; i < 10; i++) begin
            addr_in = BASE + 32'(4 * (i % 8));
            cyc(1);
        end
        check("t6_req_reads", 32'(int_req), 1);
        bus_read(5'h0C, rd); check("t6_cur_reads", rd, 32'h0000_0102);
        bus_write(5'h18, 32'hFFFF_FFFF);
        bus_read(5'h04, rd); check("t6_mask_kept", rd, 32'h05);
        bus_read(5'h08, rd); check("t6_mode_kept", rd, 32'h05);
        bus_read(5'h0C, rd); check("t6_cur_kept", rd, 32'h0000_0102);
        bus_write(5'h10, 32'h0);
        bus_read(5'h0C, rd); check("t6_cur_service", 32'(rd[9:8]), 2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_req_reset", 32'(int_req), 0);
        bus_read(5'h0C, rd); check("t6_cur_reset", rd, 0);
        bus_read(5'h04, rd); check("t6_mask_reset", rd, 0);
        cyc(1);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 199);
            irq_src = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            reset = (r == 0);
            mem_w = 1'b0;
            wdata = $urandom;
            if (r >= 1 && r < 60) begin
                mem_w = 1'b1;
                case ($urandom_range(0, 9))
                    0, 1:    addr_in = BASE + 32'h10;
                    2, 3:    addr_in = BASE + 32'h14;
                    4:       addr_in = BASE + 32'h04;
                    5:       addr_in = BASE + 32'h08;
                    6:       addr_in = BASE + 32'h00;
                    7:       addr_in = BASE + 32'($urandom_range(0, 31));
                    default: addr_in = $urandom;
                endcase
                if (addr_in == BASE + 32'h04) wdata = wdata | 32'h0F;
            end else if (r < 150) begin
                addr_in = BASE + 32'($urandom_range(0, 31));
            end else begin
                addr_in = $urandom;
            end
            cyc(1);
        end
        reset = 1'b0;
        mem_w = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
